// File: rtl/mod3_serial_reducer_if.sv
// Purpose: handshake bundle for mod3_serial_reducer (operand in, residue out).
// Latency: n/a (wiring only).
// Backpressure: in_ready gates the operand side, out_ready gates the result side.
//
// Signals:
//   in_valid  - operand offered by upstream
//   in_ready  - reducer can accept an operand
//   in_data   - IN_W-bit unsigned operand
//   out_valid - residue available
//   out_ready - downstream takes the residue
//   out_res   - residue code: 00 = 0, 01 = 1, 11 = 2 (i.e. -1); 10 is never driven
//   busy      - reducer is consuming digits
//
// master: the side that offers operands and takes results.
// slave : the reducer itself.
interface mod3_serial_reducer_if #(
  parameter int IN_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_res;
  logic            busy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_res,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_res,
    output busy
  );
endinterface

// File: rtl/mod3_serial_reducer.sv
// Purpose: serial residue-mod-3 reducer, STEP operand bits folded per clock using 4 == 1 (mod 3).
// Latency: accept edge A, result valid just after edge A+NSTEP (NSTEP = IN_W/STEP); one operand per NSTEP+2 cycles.
// Backpressure: in_ready only in IDLE; result is held stable in DONE until out_ready, no operand overlap.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high reset
//   io  - mod3_serial_reducer_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_res, busy)
//
// Parameters:
//   IN_W - operand width, a multiple of STEP
//   STEP - bits consumed per clock, even, 2 <= STEP <= IN_W
module mod3_serial_reducer #(
  parameter int IN_W = 16,
  parameter int STEP = 2
) (
  input logic                  clk,
  input logic                  rst,
  mod3_serial_reducer_if.slave io
);

  localparam int NSTEP = IN_W / STEP;
  localparam int NDIG  = STEP / 2;
  localparam int CNT_W = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [IN_W-1:0]   r_shift;
  logic [1:0]        r_acc;     // binary residue 0..2
  logic [CNT_W-1:0]  r_cnt;     // processing cycles still to go

  logic              w_accept;
  logic              w_consume;
  logic              w_last;
  logic [1:0]        w_acc_nxt;

  logic              w_in_ready;
  logic              w_out_valid;
  logic [1:0]        w_out_res;
  logic              w_busy;

  // (a + d) mod 3 for a in 0..2 and a base-4 digit d in 0..3. The sum is at
  // most 5, so a single conditional subtract brings it back into 0..2.
  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] d);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, d};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

  assign w_accept  = (r_state == S_IDLE) && io.in_valid;
  assign w_consume = (r_state == S_DONE) && io.out_ready;
  assign w_last    = (r_cnt == CNT_W'(1));

  // Each 2-bit slice of the chunk is a base-4 digit; since 4 == 1 (mod 3)
  // every digit contributes its own value, so the residue is just the
  // running digit sum reduced mod 3. Folding one digit at a time keeps every
  // intermediate inside 0..2.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int d = 0; d < NDIG; d++) begin
      w_acc_nxt = add_mod3(w_acc_nxt, r_shift[2*d +: 2]);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. DONE always returns to IDLE, never straight to RUN, so
  // an operand offered on the consume edge waits one more edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_consume) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic, all Moore so the result is stable for the whole DONE state.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_res   = 2'b00;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
      end
      S_RUN: begin
        w_busy = 1'b1;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        // Binary residue to ternary coefficient code; 2 is sent as -1.
        case (r_acc)
          2'd1:    w_out_res = 2'b01;
          2'd2:    w_out_res = 2'b11;
          default: w_out_res = 2'b00;
        endcase
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture at accept, then one STEP-bit chunk per RUN
  // cycle. There is no early exit for zero operands; the count always runs
  // the full NSTEP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_acc   <= 2'b00;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= io.in_data;
      r_acc   <= 2'b00;
      r_cnt   <= CNT_W'(NSTEP);
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_nxt;
      r_shift <= r_shift >> STEP;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = w_out_valid;
  assign io.out_res   = w_out_res;
  assign io.busy      = w_busy;

endmodule

// File: tb/tb_mod3_serial_reducer.sv
// Purpose: self-checking bench for mod3_serial_reducer in three shapes (8/2, 16/2, 16/8).
// Latency: checks NSTEP busy cycles per operand and result timing around DONE.
// Backpressure: exercises held out_ready=0, ignored in_valid, reset aborts and accept-after-consume.
module tb_mod3_serial_reducer;

  logic        clk;
  logic        rst;

  // Driver side, index 0 = 8/2, 1 = 16/2, 2 = 16/8
  logic [2:0]  d_in_valid;
  logic [2:0]  d_out_ready;
  logic [15:0] d_data;

  // Monitor side
  logic [2:0]  m_in_ready;
  logic [2:0]  m_out_valid;
  logic [2:0]  m_busy;
  logic [1:0]  m_out_res [3];

  int n_checks = 0;
  int n_pass   = 0;

  mod3_serial_reducer_if #(.IN_W(8))  if_a ();
  mod3_serial_reducer_if #(.IN_W(16)) if_b ();
  mod3_serial_reducer_if #(.IN_W(16)) if_c ();

  mod3_serial_reducer #(.IN_W(8),  .STEP(2)) u_a (.clk(clk), .rst(rst), .io(if_a));
  mod3_serial_reducer #(.IN_W(16), .STEP(2)) u_b (.clk(clk), .rst(rst), .io(if_b));
  mod3_serial_reducer #(.IN_W(16), .STEP(8)) u_c (.clk(clk), .rst(rst), .io(if_c));

  assign if_a.in_valid  = d_in_valid[0];
  assign if_a.out_ready = d_out_ready[0];
  assign if_a.in_data   = d_data[7:0];
  assign if_b.in_valid  = d_in_valid[1];
  assign if_b.out_ready = d_out_ready[1];
  assign if_b.in_data   = d_data;
  assign if_c.in_valid  = d_in_valid[2];
  assign if_c.out_ready = d_out_ready[2];
  assign if_c.in_data   = d_data;

  assign m_in_ready  = {if_c.in_ready,  if_b.in_ready,  if_a.in_ready};
  assign m_out_valid = {if_c.out_valid, if_b.out_valid, if_a.out_valid};
  assign m_busy      = {if_c.busy,      if_b.busy,      if_a.busy};
  assign m_out_res[0] = if_a.out_res;
  assign m_out_res[1] = if_b.out_res;
  assign m_out_res[2] = if_c.out_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain integer remainder of the operand, truncated to the
  // instance width, mapped to the ternary coefficient code.
  function automatic logic [1:0] model_res(input int sel, input logic [15:0] data);
    int unsigned v;
    v = (sel == 0) ? {24'd0, data[7:0]} : {16'd0, data};
    case (v % 3)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic int nstep_of(input int sel);
    case (sel)
      0:       return 8 / 2;
      1:       return 16 / 2;
      default: return 16 / 8;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where out_valid is seen (or budget ran out).
  task automatic wait_out_valid(input int sel, input string name);
    int n;
    n = 0;
    while (!m_out_valid[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, ".valid_seen"}, {31'd0, m_out_valid[sel]}, 32'd1);
  endtask

  // Full transaction: offer, count busy cycles, check result, consume.
  task automatic run_op(input int sel, input logic [15:0] data, input logic [1:0] exp_res,
                        input int exp_busy, input string name);
    int nb;
    bit rdy_bad;
    bit code_bad;
    d_data = data;
    d_in_valid[sel] = 1'b1;
    @(negedge clk);
    d_in_valid[sel] = 1'b0;
    nb = 0;
    rdy_bad = 0;
    code_bad = 0;
    while (m_busy[sel] && nb < 200) begin
      if (m_in_ready[sel]) rdy_bad = 1;
      if (m_out_res[sel] == 2'b10) code_bad = 1;
      nb++;
      @(negedge clk);
    end
    check({name, ".busy_cycles"}, nb, exp_busy);
    check({name, ".out_valid"}, {31'd0, m_out_valid[sel]}, 32'd1);
    if (m_in_ready[sel]) rdy_bad = 1;
    check({name, ".in_ready_low"}, {31'd0, rdy_bad}, 32'd0);
    check({name, ".code_legal"}, {31'd0, code_bad}, 32'd0);
    check({name, ".out_res"}, {30'd0, m_out_res[sel]}, {30'd0, exp_res});
    d_out_ready[sel] = 1'b1;
    @(negedge clk);
    d_out_ready[sel] = 1'b0;
    check({name, ".valid_drop"}, {31'd0, m_out_valid[sel]}, 32'd0);
    check({name, ".ready_back"}, {31'd0, m_in_ready[sel]}, 32'd1);
  endtask

  typedef struct {
    int          sel;
    logic [15:0] data;
    logic [1:0]  exp_res;
    int          exp_busy;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [1:0] held;
    bit bad;
    logic [31:0] r;

    vecs[0] = '{0, 16'h00FF, 2'b00, 4};
    vecs[1] = '{0, 16'd200,  2'b11, 4};
    vecs[2] = '{0, 16'd7,    2'b01, 4};
    vecs[3] = '{0, 16'd128,  2'b11, 4};
    vecs[4] = '{1, 16'hFFFF, 2'b00, 8};
    vecs[5] = '{1, 16'd1000, 2'b01, 8};
    vecs[6] = '{1, 16'd0,    2'b00, 8};
    vecs[7] = '{2, 16'hFFFF, 2'b00, 2};
    vecs[8] = '{2, 16'd1000, 2'b01, 2};
    vecs[9] = '{2, 16'd0,    2'b00, 2};

    d_in_valid  = '0;
    d_out_ready = '0;
    d_data      = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset%0d.in_ready", s),  {31'd0, m_in_ready[s]},  32'd1);
      check($sformatf("reset%0d.out_valid", s), {31'd0, m_out_valid[s]}, 32'd0);
      check($sformatf("reset%0d.busy", s),      {31'd0, m_busy[s]},      32'd0);
      check($sformatf("reset%0d.out_res", s),   {30'd0, m_out_res[s]},   32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sel, vecs[i].data, vecs[i].exp_res, vecs[i].exp_busy, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, in_valid pulses ignored
    d_data = 16'd100;
    d_in_valid[0] = 1'b1;
    @(negedge clk);
    d_in_valid[0] = 1'b0;
    wait_out_valid(0, "bp");
    held = m_out_res[0];
    check("bp.out_res", {30'd0, held}, 32'd1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      d_in_valid[0] = (k % 2 == 0);
      d_data = 16'(k * 37 + 3);
      @(negedge clk);
      if (!m_out_valid[0] || m_out_res[0] !== held || m_in_ready[0]) bad = 1;
    end
    check("bp.stable", {31'd0, bad}, 32'd0);
    d_in_valid[0] = 1'b0;
    d_out_ready[0] = 1'b1;
    @(negedge clk);
    d_out_ready[0] = 1'b0;
    check("bp.valid_drop", {31'd0, m_out_valid[0]}, 32'd0);
    check("bp.ready_back", {31'd0, m_in_ready[0]}, 32'd1);
    @(negedge clk);
    check("bp.no_capture", {31'd0, m_busy[0]}, 32'd0);

    // Reset between edges in the 2nd RUN cycle
    d_data = 16'h00AB;
    d_in_valid[0] = 1'b1;
    @(negedge clk);
    d_in_valid[0] = 1'b0;
    @(negedge clk);
    check("rst_run.busy_before", {31'd0, m_busy[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_run.busy", {31'd0, m_busy[0]}, 32'd0);
    check("rst_run.in_ready", {31'd0, m_in_ready[0]}, 32'd1);
    check("rst_run.out_valid", {31'd0, m_out_valid[0]}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_run.idle_after", {31'd0, m_in_ready[0]}, 32'd1);
    run_op(0, 16'd5, 2'b11, 4, "rst_run.next");

    // Reset while DONE discards the result
    d_data = 16'd1000;
    d_in_valid[1] = 1'b1;
    @(negedge clk);
    d_in_valid[1] = 1'b0;
    wait_out_valid(1, "rst_done");
    #2 rst = 1'b1;
    #1;
    check("rst_done.out_valid", {31'd0, m_out_valid[1]}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_done.in_ready", {31'd0, m_in_ready[1]}, 32'd1);

    // in_valid held through DONE consumption: accept only on the edge after exit
    d_data = 16'd10;
    d_in_valid[0] = 1'b1;
    @(negedge clk);
    check("hold.busy1", {31'd0, m_busy[0]}, 32'd1);
    d_data = 16'd11;
    wait_out_valid(0, "hold.op1");
    check("hold.res1", {30'd0, m_out_res[0]}, 32'd1);
    d_out_ready[0] = 1'b1;
    d_data = 16'd20;
    @(negedge clk);
    d_out_ready[0] = 1'b0;
    check("hold.exit_idle", {31'd0, m_busy[0]}, 32'd0);
    check("hold.exit_ready", {31'd0, m_in_ready[0]}, 32'd1);
    d_data = 16'd22;
    @(negedge clk);
    d_in_valid[0] = 1'b0;
    check("hold.busy2", {31'd0, m_busy[0]}, 32'd1);
    wait_out_valid(0, "hold.op2");
    check("hold.res2", {30'd0, m_out_res[0]}, 32'd1);
    d_out_ready[0] = 1'b1;
    @(negedge clk);
    d_out_ready[0] = 1'b0;

    // Random sweeps against the reference
    for (int i = 0; i < 1000; i++) begin
      r = $urandom;
      run_op(1, r[15:0], model_res(1, r[15:0]), nstep_of(1), $sformatf("rnd16_2.%0d", i));
    end
    for (int i = 0; i < 1000; i++) begin
      r = $urandom;
      run_op(2, r[15:0], model_res(2, r[15:0]), nstep_of(2), $sformatf("rnd16_8.%0d", i));
    end
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      run_op(0, r[15:0], model_res(0, r[15:0]), nstep_of(0), $sformatf("rnd8_2.%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod3_serial_reducer.md
Name: mod3_serial_reducer

Overview:
- Parametrised multi-cycle reducer: accepts an IN_W-bit unsigned operand and returns its residue mod 3 as a ternary coefficient code.
- Consumes STEP bits per clock, using 4 ≡ 1 (mod 3).
- Adds valid/ready handshakes on both sides, so it can sit between the coefficient buffer and the ternary packing stage of the NTRU-HRSS datapath.

Parameters:
- IN_W, 16, operand width in bits; must be a multiple of STEP.
- STEP, 2, bits consumed per clock; even, 2 ≤ STEP ≤ IN_W.
- NSTEP, IN_W/STEP, derived; number of processing cycles; not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand.
- in_data  input  IN_W  unsigned operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_res  output  2  residue code: 2'b00=0, 2'b01=1, 2'b11=2 (≡ −1). 2'b10 never driven.
- busy  output  1  high while in RUN.

Behaviour:
- One clock domain; reset is asynchronous and active-high. All state flops clear immediately on rst=1, independent of clk.
- Reset values: state=IDLE, acc=2'b00, shift register=0, step counter=0.
  - Output reset values: in_ready=1, out_valid=0, out_res=2'b00, busy=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1:
    - load shift register ← in_data
    - acc ← 0
    - counter ← NSTEP
    - go to RUN.
  - RUN, on each edge:
    - chunk = shift[STEP-1:0], viewed as STEP/2 two-bit digits.
    - acc ← (acc + sum of digits) mod 3.
    - shift ← shift >> STEP (zero fill).
    - counter ← counter − 1.
    - When the counter goes 1→0, go to DONE.
    - in_ready=0 and busy=1 throughout RUN.
  - DONE: out_valid=1 and out_res=code(acc), both stable until taken. On an edge with out_ready=1, go to IDLE; out_valid drops on that edge.
- Latency: accept edge A, then processing edges A+1 … A+NSTEP. out_valid is high from just after edge A+NSTEP. With defaults, 8 processing edges.
- Throughput: one operand per NSTEP+2 cycles when out_ready is held high. No overlap between operands.
- Arithmetic:
  - Digit sum ≤ 3·STEP/2; reduce it mod 3 combinationally.
  - acc is held in binary 0..2 and encoded to the out_res code only at the output.
  - The result must equal in_data mod 3 exactly for every IN_W-bit value.
- Boundary conditions:
  - in_valid while RUN or DONE is ignored and no data is captured. in_ready=0 tells upstream to hold.
  - out_ready while IDLE or RUN has no effect.
  - in_valid=1 on the same edge that DONE is consumed is not accepted. Acceptance happens on the following edge from IDLE.
  - in_data=0 gives 2'b00 after the full NSTEP cycles; there is no early exit.
  - in_data changing during RUN has no effect, because the operand is captured at accept.
  - rst asserted mid-RUN or mid-DONE aborts the operation: out_valid=0 immediately and the pending result is discarded. After rst falls, the block is in IDLE with in_ready=1.
  - out_res while out_valid=0 is don't-care for checking, but must never be 2'b10.

Test Plan:
1. IN_W=8, STEP=2: accept in_data=8'hFF, out_ready=1 → exactly 4 busy cycles, then out_valid=1 with out_res=2'b00 (255 mod 3=0).
2. IN_W=8, STEP=2: sequential operands 8'd200, 8'd7, 8'd128 → out_res 2'b11, 2'b01, 2'b11. in_ready=0 from the cycle after each accept until DONE is consumed.
3. Defaults (16/2) and IN_W=16, STEP=8:
   - 16'hFFFF → 2'b00; 16'd1000 → 2'b01; 16'd0 → 2'b00.
   - Busy cycles are 8 and 2 respectively.
   - Random sweep of 1000 operands checked against the modulo-3 model.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_res stable. in_valid pulses during that window are ignored. The result drops on the first edge with out_ready=1.
5. Reset: assert rst asynchronously (between edges) in the 2nd RUN cycle of 8'hAB → out_valid=0, in_ready=1, busy=0 immediately. A following accept of 8'd5 returns 2'b11.
6. Simultaneous events: in_valid=1 held high through DONE consumption → the new operand is captured one edge after DONE exits, not on the exit edge. This is verified by changing in_data on the exit edge.
